// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle multiply/divide unit with HI/LO result registers.
//
// MULT/MULTU use shift-add and DIV/DIVU use restoring division. Both retire one
// bit per cycle on operand magnitudes, and sign correction is applied at the end.
// A divide by zero skips the iterations: it gives lo = all ones, hi = op1 and
// div_zero = 1.
//
// Optional build macro MDU_EARLY_TERM_EN: when defined, a multiply leaves CALC
// as soon as the remaining multiplier bits are all zero. Divides are unaffected.
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous reset, active-high
//   flush      synchronous cancel of the in-flight operation
//   in_valid   request valid
//   in_ready   request can be accepted (IDLE only)
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   op1, op2   multiplicand/dividend, multiplier/divisor
//   out_valid  result valid
//   out_ready  consumer takes the result
//   hi, lo     MULT: product upper/lower; DIV: remainder/quotient
//   div_zero   result came from a divide by zero
//   busy       unit is not IDLE
module mdu_iterative #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_lo_q, neg_lo_d;   // product / quotient sign
    logic                 neg_hi_q, neg_hi_d;   // remainder sign
    logic                 dz_q, dz_d;
    // Multiply: product accumulator. Divide: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    // Multiply: multiplicand shifted left each step. Divide: divisor in low half.
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 div_zero_q, div_zero_d;

    logic                 accept;
    logic                 s1, s2;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [WIDTH:0]       rem_shift, rem_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;
    logic                 calc_last;

    assign accept = in_valid && (state_q == StIdle) && !flush;

    // Signed ops take magnitudes; |MIN| falls out as unsigned 2^(WIDTH-1).
    assign s1   = !op[0] && op1[WIDTH-1];
    assign s2   = !op[0] && op2[WIDTH-1];
    assign mag1 = s1 ? -op1 : op1;
    assign mag2 = s2 ? -op2 : op2;

    // Restoring step: bit WIDTH of the difference is the borrow, meaning that
    // the trial subtraction is rejected.
    assign rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, mcand_q[WIDTH-1:0]};

    assign prod_fix = neg_lo_q ? -acc_q : acc_q;
    assign quo_fix  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MDU_EARLY_TERM_EN
    assign calc_last = (cnt_q == CntLast) ||
                       (!is_div_q && (mplier_q[WIDTH-1:1] == '0));
`else
    assign calc_last = (cnt_q == CntLast);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        dz_d       = dz_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    is_div_d = op[1];
                    neg_lo_d = s1 ^ s2;
                    neg_hi_d = s1;
                    cnt_d    = '0;
                    mplier_d = mag2;
                    if (op[1] && (op2 == '0)) begin
                        // Raw op1 is parked so FIX can return it unmodified.
                        dz_d    = 1'b1;
                        acc_d   = {{WIDTH{1'b0}}, op1};
                        mcand_d = '0;
                        state_d = StFix;
                    end else begin
                        dz_d    = 1'b0;
                        acc_d   = {{WIDTH{1'b0}}, (op[1] ? mag1 : {WIDTH{1'b0}})};
                        mcand_d = {{WIDTH{1'b0}}, (op[1] ? mag2 : mag1)};
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntOne;
                    if (is_div_q) begin
                        if (!rem_diff[WIDTH]) begin
                            acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        if (mplier_q[0]) begin
                            acc_d = acc_q + mcand_q;
                        end
                        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                    end
                    if (calc_last) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    if (dz_q) begin
                        hi_d = acc_q[WIDTH-1:0];
                        lo_d = {WIDTH{1'b1}};
                    end else if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    div_zero_d = dz_q;
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (flush || out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dz_q       <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            dz_q       <= dz_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative (WIDTH = 32). A plain-arithmetic model
// predicts {div_zero, hi, lo} and latency. A negedge monitor compares every
// valid output cycle against the queued expectation.
module tb_mdu_iterative;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] hi, lo;
    logic        div_zero;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [64:0] exp_q[$];
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    mdu_iterative #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hi        (hi),
        .lo        (lo),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns {div_zero, hi, lo}.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            2'b00: begin
                sp = sa * sb;
                return {1'b0, sp[63:0]};
            end
            2'b01: begin
                up = ua * ub;
                return {1'b0, up[63:0]};
            end
            2'b10: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {1'b0, sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {1'b0, ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Edges to out_valid, counting the accept edge as edge 1.
    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
        logic [31:0] m;
        int          h;
        if (o[1] && (b == 32'h0)) return 2;
`ifdef MDU_EARLY_TERM_EN
        if (!o[1]) begin
            m = (!o[0] && b[31]) ? -b : b;
            h = 0;
            for (int i = 0; i < 32; i++) if (m[i]) h = i;
            return h + 3;
        end
`endif
        m = b;
        h = 0;
        return 34;
    endfunction

    // Output monitor: checks every cycle that out_valid is high.
    always @(negedge CLK) begin
        if (!RST && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", {64'b0, out_valid}, 65'd0);
            end else begin
                chk("mon_hi", {33'b0, hi}, {33'b0, exp_q[0][63:32]});
                chk("mon_lo", {33'b0, lo}, {33'b0, exp_q[0][31:0]});
                chk("mon_div_zero", {64'b0, div_zero}, {64'b0, exp_q[0][64]});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [64:0] e;
        int          n;
        e = model(o, a, b);
        exp_q.push_back(e);
        op        = o;
        op1       = a;
        op2       = b;
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        @(posedge CLK);
        #1 in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("latency", n, exp_lat(o, b));
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK);
            #1;
            chk("hold_out_valid", {64'b0, out_valid}, 65'd1);
            chk("hold_in_ready", {64'b0, in_ready}, 65'd0);
        end
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("release_out_valid", {64'b0, out_valid}, 65'd0);
        chk("release_in_ready", {64'b0, in_ready}, 65'd1);
        out_ready = 1'b0;
        last_hi = e[63:32];
        last_lo = e[31:0];
    endtask

    // Cancel a multiply near CALC iteration 10 by flush or by RST.
    task automatic cancel_test(input bit use_rst);
        bit seen;
        op       = 2'b01;
        op1      = 32'hDEAD_BEEF;
        op2      = 32'h1234_5678;
        in_valid = 1'b1;
        @(posedge CLK);
        #1 in_valid = 1'b0;
        repeat (9) begin
            @(posedge CLK);
            #1;
        end
        chk("cancel_busy_before", {64'b0, busy}, 65'd1);
        if (use_rst) begin
            RST = 1'b1;
            #1;
            chk("rst_in_ready", {64'b0, in_ready}, 65'd1);
            chk("rst_out_valid", {64'b0, out_valid}, 65'd0);
            chk("rst_hi", {33'b0, hi}, 65'd0);
            chk("rst_lo", {33'b0, lo}, 65'd0);
            @(posedge CLK);
            #1 RST = 1'b0;
            last_hi = '0;
            last_lo = '0;
        end else begin
            flush = 1'b1;
            @(posedge CLK);
            #1 flush = 1'b0;
            chk("flush_in_ready", {64'b0, in_ready}, 65'd1);
            chk("flush_out_valid", {64'b0, out_valid}, 65'd0);
            chk("flush_hi_kept", {33'b0, hi}, {33'b0, last_hi});
            chk("flush_lo_kept", {33'b0, lo}, {33'b0, last_lo});
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("cancel_no_out_valid", {64'b0, seen}, 65'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Hand-computed pins on the model.
        chk("pin_multu", model(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
            {1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
        chk("pin_mult", model(2'b00, 32'hFFFF_FFF9, 32'd6), {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFD6});
        chk("pin_div", model(2'b10, 32'hFFFF_FFEF, 32'd5), {1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFD});
        chk("pin_divu", model(2'b11, 32'd17, 32'd5), {1'b0, 32'd2, 32'd3});
        chk("pin_divz", model(2'b10, 32'h1234_5678, 32'd0), {1'b1, 32'h1234_5678, 32'hFFFF_FFFF});
        chk("pin_minm1", model(2'b10, 32'h8000_0000, 32'hFFFF_FFFF),
            {1'b0, 32'h0, 32'h8000_0000});
        chk("pin_lat_multu", exp_lat(2'b01, 32'hFFFF_FFFF), 34);
        chk("pin_lat_divz", exp_lat(2'b10, 32'd0), 2);
`ifdef MDU_EARLY_TERM_EN
        chk("pin_lat_mult6", exp_lat(2'b00, 32'd6), 5);
`else
        chk("pin_lat_mult6", exp_lat(2'b00, 32'd6), 34);
`endif

        // Asynchronous reset state.
        #12;
        chk("reset_in_ready", {64'b0, in_ready}, 65'd1);
        chk("reset_out_valid", {64'b0, out_valid}, 65'd0);
        chk("reset_busy", {64'b0, busy}, 65'd0);
        chk("reset_hi", {33'b0, hi}, 65'd0);
        chk("reset_lo", {33'b0, lo}, 65'd0);
        chk("reset_div_zero", {64'b0, div_zero}, 65'd0);
        @(posedge CLK);
        #1 RST = 1'b0;

        // Flush together with in_valid in IDLE blocks acceptance.
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("idle_flush_blocks", {64'b0, busy}, 65'd0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd6, 0);
        run_op(2'b10, 32'hFFFF_FFEF, 32'd5, 0);
        run_op(2'b11, 32'd17, 32'd5, 0);
        run_op(2'b10, 32'h1234_5678, 32'd0, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(2'b10, 32'd17, 32'hFFFF_FFFB, 0);
        run_op(2'b10, 32'hFFFF_FFEF, 32'hFFFF_FFFB, 0);
        run_op(2'b11, 32'hFFFF_FFFF, 32'd0, 0);
        run_op(2'b11, 32'd5, 32'd17, 0);
        run_op(2'b00, 32'h0001_2345, 32'd0, 0);
        run_op(2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 0);

        cancel_test(1'b0);
        run_op(2'b01, 32'h0000_FFFF, 32'h0001_0001, 0);
        cancel_test(1'b1);
        run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
